// File: rtl/vec_mem_pipe_if.sv
// vec_mem_pipe_if: write/read/clear bus between the operand loader, vec_mem_pipe and the MAC
interface vec_mem_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                    write_en;
    logic [ADDR_WIDTH-1:0]   write_address;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    read_en;
    logic [ADDR_WIDTH-1:0]   read_address;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    read_valid;
    logic                    clear_req;
    logic                    init_busy;
    modport master (
        output write_en, write_address, write_strb, data_in, read_en, read_address, clear_req,
        input  data_out, read_valid, init_busy
    );
    modport slave (
        input  write_en, write_address, write_strb, data_in, read_en, read_address, clear_req,
        output data_out, read_valid, init_busy
    );
endinterface

// File: rtl/vec_mem_pipe.sv
// vec_mem_pipe: byte-strobed dual-port vector memory with pipelined reads and a clear sweep
module vec_mem_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_SIZE       = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 2,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic clk,
    input logic rst_n,
    vec_mem_pipe_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic init_busy_q, init_busy_d;
    logic start_q, start_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] dat_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic read_valid_q, read_valid_d;
    logic wr_in, rd_in, wr_ok, rd_ok, mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] old_word, merged, rd_word, mem_wdata;
    // Requests are dropped outright while the sweep owns the array
    always_comb begin
        wr_in = {1'b0, bus.write_address} < LIMIT;
        rd_in = {1'b0, bus.read_address} < LIMIT;
        wr_ok = bus.write_en && !init_busy_q && wr_in;
        rd_ok = bus.read_en && !init_busy_q;
        old_word = wr_in ? mem_q[bus.write_address] : '0;
        merged = old_word;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = bus.write_strb[i] ? bus.data_in[8*i +: 8] : old_word[8*i +: 8];
        rd_word = !rd_in ? '0
                : (RDW_MODE == 1 && wr_ok && bus.write_address == bus.read_address) ? merged
                : mem_q[bus.read_address];
        mem_we = state_q == CLEAR || wr_ok;
        mem_waddr = state_q == CLEAR ? clr_addr_q : bus.write_address;
        mem_wdata = state_q == CLEAR ? '0 : merged;
    end
    always_comb begin
        state_d = state_q;
        clr_addr_d = clr_addr_q;
        init_busy_d = init_busy_q;
        start_d = start_q;
        if (state_q == IDLE && (start_q || bus.clear_req)) begin
            state_d = CLEAR;
            clr_addr_d = '0;
            init_busy_d = 1'b1;
            start_d = 1'b0;
        end else if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            state_d = clr_addr_q == LAST ? IDLE : CLEAR;
            init_busy_d = clr_addr_q != LAST;
        end
    end
    always_comb begin
        vld_d = vld_q;
        vld_d[0] = rd_ok;
        dat_d = dat_q;
        dat_d[0] = rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        read_valid_d = vld_q[READ_LATENCY-1];
        data_out_d = vld_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1] : data_out_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr_addr_q <= '0;
            init_busy_q <= 1'b0;
            start_q <= CLEAR_ON_RESET != 0;
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
            data_out_q <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
            init_busy_q <= init_busy_d;
            start_q <= start_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
            data_out_q <= data_out_d;
            read_valid_q <= read_valid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
    assign bus.data_out = data_out_q;
    assign bus.read_valid = read_valid_q;
    assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_vec_mem_pipe.sv
// tb_vec_mem_pipe: directed checks of two vec_mem_pipe configurations against a behavioural model
module tb_vec_mem_pipe;
    logic clk = 1'b0;
    logic rst_n, we, re, cr;
    logic [3:0] wa, ra, ws;
    logic [31:0] di;
    int n_chk = 0;
    int n_fail = 0;
    bit started = 0;
    int cyc = 0;
    int sz [2] = '{16, 12};
    int rdw [2] = '{0, 1};
    logic [31:0] mm [2][16];
    bit pend [2], exp_b [2], exp_v [2];
    int idx [2];
    logic [31:0] exp_d [2];
    bit ring_v [2][8];
    logic [31:0] ring_d [2][8];
    always #5 clk = ~clk;
    vec_mem_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b0 ();
    vec_mem_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();
    assign b0.write_en = we;
    assign b0.write_address = wa;
    assign b0.write_strb = ws;
    assign b0.data_in = di;
    assign b0.read_en = re;
    assign b0.read_address = ra;
    assign b0.clear_req = cr;
    assign b1.write_en = we;
    assign b1.write_address = wa;
    assign b1.write_strb = ws;
    assign b1.data_in = di;
    assign b1.read_en = re;
    assign b1.read_address = ra;
    assign b1.clear_req = cr;
    vec_mem_pipe #(.DATA_WIDTH(32), .MEM_SIZE(16), .ADDR_WIDTH(4), .READ_LATENCY(2),
                   .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    vec_mem_pipe #(.DATA_WIDTH(32), .MEM_SIZE(12), .ADDR_WIDTH(4), .READ_LATENCY(2),
                   .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        merge = o;
        for (int i = 0; i < 4; i++) if (s[i]) merge[8*i +: 8] = n[8*i +: 8];
    endfunction
    // Edge-by-edge model: a read accepted at edge n is scheduled for edge n+2
    task automatic model_update();
        logic [31:0] nw;
        bit acc, win;
        int slot;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                exp_b[d] = 0; pend[d] = 1; idx[d] = 0; exp_v[d] = 0; exp_d[d] = 0;
                for (int j = 0; j < 8; j++) ring_v[d][j] = 0;
            end else begin
                acc = !exp_b[d];
                win = int'(wa) < sz[d];
                nw = win ? merge(mm[d][wa], di, ws) : 32'h0;
                if (re && acc) begin
                    slot = (cyc + 2) % 8;
                    ring_v[d][slot] = 1;
                    ring_d[d][slot] = int'(ra) >= sz[d] ? 32'h0
                                    : (rdw[d] == 1 && we && win && wa == ra) ? nw : mm[d][ra];
                end
                if (we && acc && win) mm[d][wa] = nw;
                if (exp_b[d]) begin
                    mm[d][idx[d]] = 32'h0;
                    idx[d]++;
                    if (idx[d] == sz[d]) exp_b[d] = 0;
                end else if (pend[d] || cr) begin
                    exp_b[d] = 1; idx[d] = 0; pend[d] = 0;
                end
                slot = cyc % 8;
                exp_v[d] = ring_v[d][slot];
                if (ring_v[d][slot]) exp_d[d] = ring_d[d][slot];
                ring_v[d][slot] = 0;
            end
        end
    endtask
    always @(negedge clk) begin
        if (started) begin
            check("m0_valid", 32'(b0.read_valid), 32'(exp_v[0]));
            check("m0_busy", 32'(b0.init_busy), 32'(exp_b[0]));
            check("m0_data", b0.data_out, exp_d[0]);
            check("m1_valid", 32'(b1.read_valid), 32'(exp_v[1]));
            check("m1_busy", 32'(b1.init_busy), 32'(exp_b[1]));
            check("m1_data", b1.data_out, exp_d[1]);
        end
    end
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1; wa = a; di = d; ws = s;
        tick();
        we = 0;
    endtask
    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
        re = 1; ra = a;
        tick();
        re = 0;
        tick();
        check({name, "_early0"}, 32'(b0.read_valid), 0);
        check({name, "_early1"}, 32'(b1.read_valid), 0);
        tick();
        check({name, "_valid0"}, 32'(b0.read_valid), 1);
        check({name, "_valid1"}, 32'(b1.read_valid), 1);
        check({name, "_data0"}, b0.data_out, e0);
        check({name, "_data1"}, b1.data_out, e1);
    endtask
    task automatic sweep_len(input string name);
        int c0 = 0;
        int c1 = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (b0.init_busy) c0++;
            if (b1.init_busy) c1++;
        end
        check({name, "_sweep0"}, c0, 16);
        check({name, "_sweep1"}, c1, 12);
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((b0.init_busy || b1.init_busy) && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 40), 1);
    endtask
    initial begin
        rst_n = 0; we = 0; re = 0; cr = 0; wa = 0; ra = 0; ws = 0; di = 0;
        tick();
        started = 1;
        tick();
        tick();
        check("rst_valid", 32'(b0.read_valid), 0);
        check("rst_data", b0.data_out, 0);
        check("rst_busy", 32'(b0.init_busy), 0);
        rst_n = 1;
        sweep_len("por");
        rd_check("clr5", 4'd5, 32'h0, 32'h0);
        wr(4'd1, 32'h11223344, 4'hF);
        wr(4'd1, 32'hAABBCCDD, 4'b0101);
        rd_check("strb", 4'd1, 32'h11BB33DD, 32'h11BB33DD);
        wr(4'd1, 32'hFFFFFFFF, 4'h0);
        rd_check("strb0", 4'd1, 32'h11BB33DD, 32'h11BB33DD);
        for (int i = 0; i < 4; i++) wr(4'(i), 32'hA0 + 32'(i), 4'hF);
        for (int i = 0; i < 6; i++) begin
            re = i < 4; ra = 4'(i);
            tick();
            check("pipe_valid", 32'(b0.read_valid), 32'(i >= 2));
            if (i >= 2) begin
                check("pipe_data0", b0.data_out, 32'hA0 + 32'(i - 2));
                check("pipe_data1", b1.data_out, 32'hA0 + 32'(i - 2));
            end
        end
        re = 0;
        tick();
        check("pipe_end", 32'(b0.read_valid), 0);
        wr(4'd2, 32'h5, 4'hF);
        we = 1; wa = 2; di = 32'hA5; ws = 4'hF; re = 1; ra = 2;
        tick();
        we = 0; re = 0;
        tick();
        tick();
        check("rdw_data0", b0.data_out, 32'h5);
        check("rdw_data1", b1.data_out, 32'hA5);
        rd_check("rdw_after", 4'd2, 32'hA5, 32'hA5);
        re = 1; ra = 0;
        tick();
        re = 0; cr = 1;
        tick();
        cr = 0; we = 1; wa = 3; di = 32'h33; ws = 4'hF;
        tick();
        check("preclr_valid0", 32'(b0.read_valid), 1);
        check("preclr_data0", b0.data_out, 32'hA0);
        check("preclr_data1", b1.data_out, 32'hA0);
        check("preclr_busy", 32'(b0.init_busy), 1);
        wa = 0; di = 32'h77;
        tick();
        tick();
        we = 0;
        wait_idle();
        rd_check("clr_w3", 4'd3, 32'h0, 32'h0);
        rd_check("clr_w0", 4'd0, 32'h0, 32'h0);
        wr(4'd13, 32'hDEADBEEF, 4'hF);
        rd_check("oor13", 4'd13, 32'hDEADBEEF, 32'h0);
        rd_check("oor12", 4'd12, 32'h0, 32'h0);
        re = 1; ra = 13;
        tick();
        re = 0; rst_n = 0;
        tick();
        check("flush_valid0", 32'(b0.read_valid), 0);
        check("flush_data0", b0.data_out, 32'h0);
        tick();
        check("flush_late0", 32'(b0.read_valid), 0);
        check("flush_late1", 32'(b1.read_valid), 0);
        rst_n = 1;
        sweep_len("flush");
        cr = 1;
        tick();
        cr = 0;
        repeat (5) tick();
        check("mid_busy0", 32'(b0.init_busy), 1);
        check("mid_busy1", 32'(b1.init_busy), 1);
        rst_n = 0;
        tick();
        check("midrst_busy0", 32'(b0.init_busy), 0);
        check("midrst_busy1", 32'(b1.init_busy), 0);
        check("midrst_valid1", 32'(b1.read_valid), 0);
        rst_n = 1;
        sweep_len("restart");
        rd_check("post13", 4'd13, 32'h0, 32'h0);
        started = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_mem_pipe.md
Name: vec_mem_pipe

Overview:
- Parametrised simple dual-port vector memory for the dotProduct datapath; successor to the single-cycle mem2 store.
- Adds byte-lane write strobes, a configurable read pipeline with a valid flag, a selectable read-during-write policy, and a clear sequencer.
- Sits between the operand loader and the dot-product MAC; one write port, one read port, one clock.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEM_SIZE, 16, number of words; must satisfy MEM_SIZE <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 4, address width of both ports.
- READ_LATENCY, 2, cycles from read_en sample to read_valid; legal range 1..4.
- RDW_MODE, 0, same-address read/write collision policy: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1, 1 = run the clear sweep automatically after reset release; 0 = memory contents undefined after reset.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- write_en  in  1  write request, sampled on the rising edge.
- write_address  in  ADDR_WIDTH  write word address.
- write_strb  in  DATA_WIDTH/8  per-byte write enable; bit i controls data_in[8i+7:8i].
- data_in  in  DATA_WIDTH  write data.
- read_en  in  1  read request, sampled on the rising edge.
- read_address  in  ADDR_WIDTH  read word address.
- data_out  out  DATA_WIDTH  read data; valid while read_valid=1.
- read_valid  out  1  one-cycle pulse per accepted read.
- clear_req  in  1  single-cycle request to zero the whole memory.
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (rst_n=0 at an edge): data_out=0, read_valid=0, all read-pipeline stages flushed, FSM to IDLE.
- init_busy is 0 during reset. If CLEAR_ON_RESET=1, the first edge with rst_n=1 enters CLEAR.
- FSM states:
  - IDLE: normal operation; clear_req=1 -> CLEAR.
  - CLEAR: writes 0 to address 0, 1, ..., MEM_SIZE-1, one word per cycle; after the last address -> IDLE.
  - The sweep takes exactly MEM_SIZE cycles with init_busy=1; init_busy falls on the edge that writes the last address.
  - clear_req during CLEAR is ignored. Reset during CLEAR aborts the sweep; it restarts only if CLEAR_ON_RESET=1.
- While init_busy=1: write_en and read_en are ignored. No write occurs, no read_valid is produced, and there is no queuing.
- Reads already in the pipeline when a clear starts still complete and return their pre-clear data.
- Write: on an edge with write_en=1, each byte lane whose strobe bit is set is updated; other lanes keep their value. write_strb=0 leaves the word unchanged.
- Read: read_en=1 sampled at edge k drives data_out and asserts read_valid at edge k+READ_LATENCY. Fully pipelined: back-to-back reads on consecutive cycles give back-to-back valid pulses in order.
- data_out holds its last value while read_valid=0.
- Collision (read_en, write_en, same address, same edge):
  - RDW_MODE=0: returns the word as it was before the write.
  - RDW_MODE=1: returns the merged word (new bytes on strobed lanes, old bytes elsewhere).
  - Different addresses: no interaction.
- Out-of-range address (>= MEM_SIZE): writes are dropped; reads return 0 with read_valid asserted at normal latency.
- Reads never return X for in-range addresses once a clear has completed.

Test Plan:
- Reset-clear: rst_n=0 for 3 cycles, then release -> init_busy=1 for exactly 16 cycles; afterwards read addr 5 -> data_out=0x00000000, read_valid 2 cycles after read_en.
- Strobed write: write addr 1 data 0x11223344 strb 4'hF, then addr 1 data 0xAABBCCDD strb 4'b0101; read addr 1 -> 0x11BB33DD.
- Pipelined reads: addr 0..3 preloaded with 0xA0..0xA3; read_en high 4 consecutive cycles on addr 0..3 -> read_valid high 4 consecutive cycles starting 2 cycles later, data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Collision: addr 2 holds 0x5; same-edge write 0xA5 strb 4'hF and read of addr 2 -> RDW_MODE=0 returns 0x5; RDW_MODE=1 returns 0xA5.
- Clear-during-traffic: clear_req pulse, then write addr 3 on the next cycle -> write ignored; read addr 3 after init_busy falls -> 0x0. A read issued 1 cycle before clear_req still returns its old data.
- Out-of-range and mid-sweep reset (MEM_SIZE=12): write addr 13 dropped, read addr 13 -> 0x0 with read_valid; rst_n=0 at sweep cycle 6 -> init_busy=0 and read_valid=0; a full 12-cycle sweep restarts after release.
